// File: rtl/pid_controller_pipe.sv
// pid_controller_pipe: two-stage pipelined PID controller with run-time gains.
//   Stage 1 (sampling edge): error, error delta, and the three gain products,
//   each scaled down by FRAC_W with floor rounding.
//   Stage 2 (next edge): saturating integrator, P+I+D sum, clamp to output range.
// Ports:
//   clk, rst         - clock; asynchronous active-high reset
//   setpoint         - unsigned target value (DATA_W)
//   feedback         - unsigned measured value (DATA_W)
//   sample_valid     - setpoint/feedback sampled this cycle
//   cfg_we           - configuration write strobe
//   cfg_sel          - 0=Kp, 1=Ki, 2=Kd, 3=clear integrator
//   cfg_data         - unsigned gain (COEF_W, FRAC_W fractional bits)
//   control_out      - registered, saturated controller output (DATA_W)
//   out_valid        - one-cycle pulse marking a new control_out
module pid_controller_pipe #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 9,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] feedback,
    input  logic              sample_valid,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [COEF_W-1:0] cfg_data,
    output logic [DATA_W-1:0] control_out,
    output logic              out_valid
);
    localparam int ERR_W  = DATA_W + 1;
    localparam int DIFF_W = DATA_W + 2;
    // Signed gain (COEF_W+1) times signed diff (DIFF_W) fits without loss.
    localparam int PROD_W = COEF_W + DIFF_W + 1;
    localparam int INT_W  = DATA_W + 2;
    // Sum of three PROD_W terms plus the integrator cannot overflow.
    localparam int SUM_W  = PROD_W + 2;

    localparam logic signed [SUM_W-1:0] LIM      = SUM_W'((1 << DATA_W) - 1);
    localparam logic signed [SUM_W-1:0] NEG_LIM  = -LIM;
    localparam logic signed [SUM_W-1:0] SUM_ZERO = '0;

    logic [COEF_W-1:0]        kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic signed [ERR_W-1:0]  prev_err_q, prev_err_d;
    logic signed [PROD_W-1:0] p_q, p_d, iinc_q, iinc_d, dterm_q, dterm_d;
    logic                     vld_q, vld_d;
    logic signed [INT_W-1:0]  integ_q, integ_d;
    logic [DATA_W-1:0]        control_out_q, control_out_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [ERR_W-1:0]  err;
    logic signed [DIFF_W-1:0] diff;
    logic signed [SUM_W-1:0]  integ_base, integ_sum, integ_sat, sum;
    logic                     clr;

    // Gains: products below read the old registered gain, so a write lands
    // on samples accepted in the following cycle or later.
    always_comb begin
        kp_d = kp_q;
        ki_d = ki_q;
        kd_d = kd_q;
        if (cfg_we) begin
            case (cfg_sel)
                2'd0:    kp_d = cfg_data;
                2'd1:    ki_d = cfg_data;
                2'd2:    kd_d = cfg_data;
                default: ;
            endcase
        end
    end

    // Stage 1
    always_comb begin
        err        = $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
        diff       = DIFF_W'(err) - DIFF_W'(prev_err_q);
        vld_d      = sample_valid;
        prev_err_d = prev_err_q;
        p_d        = p_q;
        iinc_d     = iinc_q;
        dterm_d    = dterm_q;
        if (sample_valid) begin
            prev_err_d = err;
            // >>> on a signed value floors toward minus infinity.
            p_d     = ($signed(PROD_W'(kp_q)) * PROD_W'(err))  >>> FRAC_W;
            iinc_d  = ($signed(PROD_W'(ki_q)) * PROD_W'(err))  >>> FRAC_W;
            dterm_d = ($signed(PROD_W'(kd_q)) * PROD_W'(diff)) >>> FRAC_W;
        end
    end

    // Stage 2: a clear in this cycle zeroes the integrator before the
    // sample in stage 2 accumulates into it.
    always_comb begin
        clr        = cfg_we && (cfg_sel == 2'd3);
        integ_base = clr ? SUM_ZERO : SUM_W'(integ_q);
        integ_sum  = integ_base + SUM_W'(iinc_q);
        if (integ_sum > LIM)          integ_sat = LIM;
        else if (integ_sum < NEG_LIM) integ_sat = NEG_LIM;
        else                          integ_sat = integ_sum;
        sum = SUM_W'(p_q) + integ_sat + SUM_W'(dterm_q);

        integ_d       = INT_W'(integ_base);
        control_out_d = control_out_q;
        out_valid_d   = vld_q;
        if (vld_q) begin
            integ_d = INT_W'(integ_sat);
            if (sum <= SUM_ZERO)  control_out_d = '0;
            else if (sum >= LIM)  control_out_d = '1;
            else                  control_out_d = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kp_q          <= '0;
            ki_q          <= '0;
            kd_q          <= '0;
            prev_err_q    <= '0;
            p_q           <= '0;
            iinc_q        <= '0;
            dterm_q       <= '0;
            vld_q         <= 1'b0;
            integ_q       <= '0;
            control_out_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            kp_q          <= kp_d;
            ki_q          <= ki_d;
            kd_q          <= kd_d;
            prev_err_q    <= prev_err_d;
            p_q           <= p_d;
            iinc_q        <= iinc_d;
            dterm_q       <= dterm_d;
            vld_q         <= vld_d;
            integ_q       <= integ_d;
            control_out_q <= control_out_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign control_out = control_out_q;
    assign out_valid   = out_valid_q;
endmodule

// File: tb/tb_pid_controller_pipe.sv
// Bench for pid_controller_pipe: scenario tasks push expected outputs to a
// scoreboard queue as samples are driven; a negedge monitor pops and compares
// on every out_valid pulse.
module tb_pid_controller_pipe;
    localparam int DATA_W = 8;
    localparam int COEF_W = 9;
    localparam int FRAC_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] setpoint = '0;
    logic [DATA_W-1:0] feedback = '0;
    logic              sample_valid = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_sel = '0;
    logic [COEF_W-1:0] cfg_data = '0;
    logic [DATA_W-1:0] control_out;
    logic              out_valid;

    int n_cmp = 0;
    int n_err = 0;
    int sb[$];
    int m_prev = 0;

    pid_controller_pipe #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .setpoint(setpoint), .feedback(feedback),
        .sample_valid(sample_valid), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_data(cfg_data), .control_out(control_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL stray_out_valid: got pulse with control_out=%0d, none expected", control_out);
            end else begin
                int e;
                e = sb.pop_front();
                if (control_out !== DATA_W'(e)) begin
                    n_err++;
                    $display("FAIL control_out: got %0d, expected %0d", control_out, e);
                end
            end
        end
    end

    // One clock cycle with the given inputs; returns at the following negedge.
    task automatic cyc(input logic sv, input int sp, input int fb,
                       input logic we, input logic [1:0] sel, input int data);
        sample_valid = sv;
        setpoint     = DATA_W'(sp);
        feedback     = DATA_W'(fb);
        cfg_we       = we;
        cfg_sel      = sel;
        cfg_data     = COEF_W'(data);
        @(negedge clk);
        sample_valid = 1'b0;
        cfg_we       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic cfg(input logic [1:0] sel, input int data);
        cyc(0, 0, 0, 1, sel, data);
    endtask

    task automatic smp(input int sp, input int fb, input int exp);
        sb.push_back(exp);
        m_prev = sp - fb;
        cyc(1, sp, fb, 0, 2'd0, 0);
    endtask

    task automatic gains(input int kp, input int ki, input int kd);
        cfg(2'd0, kp);
        cfg(2'd1, ki);
        cfg(2'd2, kd);
        cfg(2'd3, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_prev = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (control_out !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got out=%0d vld=%b, expected 0/0", control_out, out_valid);
        end
        do_reset();
        cfg(2'd0, 16);
        smp(100, 40, 60);
        idle(3);
        // Sample in stage 1 when reset hits; its output must never appear.
        sample_valid = 1'b1;
        setpoint = 8'd150;
        feedback = 8'd50;
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (control_out !== '0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got out=%0d vld=%b, expected 0/0", control_out, out_valid);
        end
        m_prev = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        // Gains were cleared by reset.
        smp(100, 40, 0);
        idle(3);
    endtask

    task automatic test_d_only();
        do_reset();
        gains(0, 0, 16);
        smp(20, 0, 20);
        smp(20, 0, 0);
        smp(5, 0, 0);
        idle(3);
    endtask

    task automatic test_p_only();
        logic ov_first, ov_second;
        gains(16, 0, 0);
        smp(100, 40, 60);
        ov_first = out_valid;
        idle(1);
        ov_second = out_valid;
        n_cmp++;
        if (ov_first !== 1'b0 || ov_second !== 1'b1) begin
            n_err++;
            $display("FAIL latency: got vld after edge1=%b edge2=%b, expected 0 then 1", ov_first, ov_second);
        end
        cfg(2'd0, 32);
        smp(200, 0, 255);
        smp(10, 250, 0);
        idle(3);
    endtask

    task automatic test_i_only();
        gains(0, 16, 0);
        for (int k = 1; k <= 33; k++) smp(10, 0, (10 * k > 255) ? 255 : 10 * k);
        smp(0, 10, 245);
        idle(3);
        // Ki = 0.5: Iinc(11)=5, Iinc(-3)=floor(-1.5)=-2 -> integ 3.
        gains(0, 8, 0);
        smp(11, 0, 5);
        smp(0, 3, 3);
        idle(3);
    endtask

    task automatic test_concurrency();
        gains(0, 0, 0);
        // Kp write in the same cycle as the sample: that sample uses Kp=0.
        sb.push_back(0);
        m_prev = 30;
        cyc(1, 30, 0, 1, 2'd0, 16);
        smp(30, 0, 30);
        idle(3);
        gains(0, 16, 0);
        smp(100, 0, 100);
        idle(3);
        // Sample err=5 in stage 2 at the clear edge: integ = sat(5).
        smp(5, 0, 5);
        cfg(2'd3, 0);
        smp(5, 0, 10);
        idle(3);
    endtask

    task automatic test_back_to_back();
        int sp[8] = '{50, 120, 30, 200, 90, 255, 0, 128};
        int fb[8] = '{10, 20, 100, 0, 90, 5, 40, 64};
        logic [7:0] ov;
        logic ov0;
        gains(16, 0, 16);
        for (int i = 0; i < 8; i++) begin
            int err, e;
            err = sp[i] - fb[i];
            e = err + (err - m_prev);
            if (e < 0) e = 0;
            if (e > 255) e = 255;
            smp(sp[i], fb[i], e);
            if (i == 0) ov0 = out_valid;
            else ov[i-1] = out_valid;
        end
        idle(1);
        ov[7] = out_valid;
        n_cmp++;
        if (ov0 !== 1'b0 || ov !== 8'hFF) begin
            n_err++;
            $display("FAIL back_to_back_pulses: got first=%b pulses=%b, expected 0 / 11111111", ov0, ov);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_d_only();
        test_p_only();
        test_i_only();
        test_concurrency();
        test_back_to_back();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d outputs missing, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
